// File: rtl/card_dealer.sv
// card_dealer: owns the 52-card deck; fills it from the shuffle source,
// then deals single cards to the player/dealer with round-robin arbitration.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   o_shuffle_req, i_load_valid, i_load_card, o_load_ready  (fill side)
//   i_reshuffle, i_req_player, i_req_dealer                 (control/requests)
//   o_grant_player, o_grant_dealer, o_card_out,
//   o_card_value, o_is_ace                                  (registered deal result)
//   o_remaining, o_deck_ready, o_low_deck, o_load_error     (status)
// Optional macro CARD_DEALER_DUP_CHECK_EN: rejects duplicate or
// out-of-range loads, sets sticky o_load_error and restarts the fill.
// Undefined: cards are written unchecked, o_load_error is tied to 0.
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 6,
    parameter int LOW_MARK  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_shuffle_req,
    input  logic              i_load_valid,
    input  logic [CARD_W-1:0] i_load_card,
    output logic              o_load_ready,
    input  logic              i_reshuffle,
    input  logic              i_req_player,
    input  logic              i_req_dealer,
    output logic              o_grant_player,
    output logic              o_grant_dealer,
    output logic [CARD_W-1:0] o_card_out,
    output logic [3:0]        o_card_value,
    output logic              o_is_ace,
    output logic [5:0]        o_remaining,
    output logic              o_deck_ready,
    output logic              o_low_deck,
    output logic              o_load_error
);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_EMPTY} state_t;

    localparam logic [CARD_W-1:0] LAST = CARD_W'(DECK_SIZE - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CARD_W-1:0] r_mem [DECK_SIZE];
    logic [CARD_W-1:0] r_wr_ptr;
    logic [CARD_W-1:0] r_rd_ptr;
    logic [5:0]        r_remaining;
    logic              r_prio_dealer;
    logic              r_grant_p;
    logic              r_grant_d;
    logic [CARD_W-1:0] r_card;
    logic [3:0]        r_value;
    logic              r_ace;

    logic              w_wr_en;
    logic              w_restart;
    logic              w_load_bad;
    logic              w_deal;
    logic              w_gp;
    logic              w_gd;
    logic              w_bad;
    logic [CARD_W-1:0] w_rd_card;
    logic [CARD_W-1:0] w_rank;
    logic [3:0]        w_value;
    logic              w_ace;

`ifdef CARD_DEALER_DUP_CHECK_EN
    logic [DECK_SIZE-1:0] r_seen;
    logic                 r_load_error;

    // Out-of-range cards are rejected before the mask is consulted.
    assign w_bad = (i_load_card >= CARD_W'(DECK_SIZE)) || r_seen[i_load_card];
    assign o_load_error = r_load_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen       <= '0;
            r_load_error <= 1'b0;
        end else if (w_restart) begin
            r_seen       <= '0;
            r_load_error <= 1'b0;
        end else if (w_load_bad) begin
            r_seen       <= '0;
            r_load_error <= 1'b1;
        end else if (w_wr_en) begin
            r_seen[i_load_card] <= 1'b1;
        end
    end
`else
    assign w_bad        = 1'b0;
    assign o_load_error = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_LOAD;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_restart   = 1'b0;
        w_load_bad  = 1'b0;
        w_deal      = 1'b0;
        w_gp        = 1'b0;
        w_gd        = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                if (i_reshuffle) begin
                    w_restart = 1'b1;
                end else if (i_load_valid) begin
                    if (w_bad) begin
                        w_load_bad = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_wr_ptr == LAST) w_state_nxt = S_READY;
                    end
                end
            end
            S_READY: begin
                // Reshuffle beats any simultaneous request.
                if (i_reshuffle) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (i_req_player || i_req_dealer) begin
                    w_deal = 1'b1;
                    if (i_req_player && i_req_dealer) begin
                        w_gp = !r_prio_dealer;
                        w_gd = r_prio_dealer;
                    end else begin
                        w_gp = i_req_player;
                        w_gd = i_req_dealer;
                    end
                    if (r_remaining == 6'd1) w_state_nxt = S_EMPTY;
                end
            end
            S_EMPTY: begin
                if (i_reshuffle) begin
                    w_restart   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    assign w_rd_card = r_mem[r_rd_ptr];
    assign w_rank    = w_rd_card % CARD_W'(13);

    always_comb begin
        w_value = 4'd0;
        w_ace   = 1'b0;
        if (w_rd_card < CARD_W'(DECK_SIZE)) begin
            if (w_rank == '0) begin
                w_value = 4'd1;
                w_ace   = 1'b1;
            end else if (w_rank <= CARD_W'(8)) begin
                w_value = w_rank[3:0] + 4'd1;
            end else begin
                w_value = 4'd10;
            end
        end
    end

    // Deck storage has no reset; contents are only read after a full fill.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_load_card;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_remaining   <= '0;
            r_prio_dealer <= 1'b0;
            r_grant_p     <= 1'b0;
            r_grant_d     <= 1'b0;
            r_card        <= '0;
            r_value       <= '0;
            r_ace         <= 1'b0;
        end else begin
            r_grant_p <= w_gp;
            r_grant_d <= w_gd;
            if (w_restart) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_remaining <= '0;
            end else if (w_load_bad) begin
                r_wr_ptr <= '0;
            end else if (w_wr_en) begin
                if (r_wr_ptr == LAST) begin
                    r_wr_ptr    <= '0;
                    r_rd_ptr    <= '0;
                    r_remaining <= 6'(DECK_SIZE);
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end else if (w_deal) begin
                r_card        <= w_rd_card;
                r_value       <= w_value;
                r_ace         <= w_ace;
                r_rd_ptr      <= r_rd_ptr + 1'b1;
                r_remaining   <= r_remaining - 6'd1;
                // After a player grant the dealer wins the next tie.
                r_prio_dealer <= w_gp;
            end
        end
    end

    assign o_shuffle_req  = (r_state == S_LOAD);
    assign o_load_ready   = (r_state == S_LOAD);
    assign o_deck_ready   = (r_state == S_READY);
    assign o_low_deck     = (r_state == S_READY) &&
                            (r_remaining <= 6'(LOW_MARK));
    assign o_remaining    = r_remaining;
    assign o_grant_player = r_grant_p;
    assign o_grant_dealer = r_grant_d;
    assign o_card_out     = r_card;
    assign o_card_value   = r_value;
    assign o_is_ace       = r_ace;

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: directed steps with a scoreboard of
// expected grants and a small behavioural model of the deck.
module tb_card_dealer;

    logic       clk;
    logic       rst_n;
    logic       shuffle_req;
    logic       load_valid;
    logic [5:0] load_card;
    logic       load_ready;
    logic       reshuffle;
    logic       req_player;
    logic       req_dealer;
    logic       grant_player;
    logic       grant_dealer;
    logic [5:0] card_out;
    logic [3:0] card_value;
    logic       is_ace;
    logic [5:0] remaining;
    logic       deck_ready;
    logic       low_deck;
    logic       load_error;

    card_dealer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .o_shuffle_req  (shuffle_req),
        .i_load_valid   (load_valid),
        .i_load_card    (load_card),
        .o_load_ready   (load_ready),
        .i_reshuffle    (reshuffle),
        .i_req_player   (req_player),
        .i_req_dealer   (req_dealer),
        .o_grant_player (grant_player),
        .o_grant_dealer (grant_dealer),
        .o_card_out     (card_out),
        .o_card_value   (card_value),
        .o_is_ace       (is_ace),
        .o_remaining    (remaining),
        .o_deck_ready   (deck_ready),
        .o_low_deck     (low_deck),
        .o_load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       gp;
        logic       gd;
        logic [5:0] card;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: 0 LOAD, 1 READY, 2 EMPTY
    int         m_state;
    int         m_wr;
    int         m_rd;
    int         m_rem;
    logic       m_prio_d;
    logic       m_err;
    logic [5:0] m_last;
    logic [5:0] m_mem [52];
    logic [51:0] m_seen;
    int         deck [52];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] val_of(input logic [5:0] c);
        int r;
        r = int'(c) % 13;
        if (c >= 6'd52) return 4'd0;
        if (r == 0) return 4'd1;
        if (r < 9) return 4'(r + 1);
        return 4'd10;
    endfunction

    task automatic reset_model();
        m_state  = 0;
        m_wr     = 0;
        m_rd     = 0;
        m_rem    = 0;
        m_prio_d = 1'b0;
        m_err    = 1'b0;
        m_last   = '0;
        m_seen   = '0;
        q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant_player", grant_player, e.gp);
            chk("grant_dealer", grant_dealer, e.gd);
            chk("card_out", card_out, e.card);
            chk("card_value", card_value, val_of(e.card));
            chk("is_ace", is_ace, (e.card < 52) && (e.card % 13 == 0));
            m_last = e.card;
        end else begin
            chk("no_grant", {grant_player, grant_dealer}, 2'b00);
            chk("card_hold", card_out, m_last);
        end
        chk("shuffle_req", shuffle_req, m_state == 0);
        chk("load_ready", load_ready, m_state == 0);
        chk("deck_ready", deck_ready, m_state == 1);
        chk("remaining", remaining, m_rem);
        chk("low_deck", low_deck, (m_state == 1) && (m_rem <= 15));
        chk("load_error", load_error, m_err);
    endtask

    task automatic step(input logic p, input logic d, input logic rs);
        exp_t e;
        req_player = p;
        req_dealer = d;
        reshuffle  = rs;
        if (rs) begin
            m_state = 0;
            m_wr    = 0;
            m_rd    = 0;
            m_rem   = 0;
            m_err   = 1'b0;
            m_seen  = '0;
        end else if (m_state == 1 && (p || d)) begin
            if (p && d) begin
                e.gp = !m_prio_d;
                e.gd = m_prio_d;
            end else begin
                e.gp = p;
                e.gd = d;
            end
            e.card = m_mem[m_rd];
            q.push_back(e);
            m_prio_d = e.gp;
            m_rd++;
            m_rem--;
            if (m_rem == 0) m_state = 2;
        end
        tick();
        req_player = 1'b0;
        req_dealer = 1'b0;
        reshuffle  = 1'b0;
        check_all();
    endtask

    task automatic feed(input int c);
        logic bad;
        load_valid = 1'b1;
        load_card  = 6'(c);
        if (m_state == 0) begin
`ifdef CARD_DEALER_DUP_CHECK_EN
            bad = (c >= 52) || m_seen[c];
`else
            bad = 1'b0;
`endif
            if (bad) begin
                m_err  = 1'b1;
                m_wr   = 0;
                m_seen = '0;
            end else begin
                m_mem[m_wr] = 6'(c);
                m_seen[c]   = 1'b1;
                m_wr++;
                if (m_wr == 52) begin
                    m_state = 1;
                    m_wr    = 0;
                    m_rd    = 0;
                    m_rem   = 52;
                end
            end
        end
        tick();
        load_valid = 1'b0;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_card  = '0;
        reshuffle  = 1'b0;
        req_player = 1'b0;
        req_dealer = 1'b0;
        reset_model();

        deck[0] = 13;
        deck[1] = 9;
        deck[2] = 0;
        k = 3;
        for (int c = 1; c < 52; c++) begin
            if (c != 13 && c != 9) begin
                deck[k] = c;
                k++;
            end
        end

        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with load_valid every other cycle
        for (int i = 0; i < 52; i++) begin
            feed(deck[i]);
            if (i != 51) step(1'b0, 1'b0, 1'b0);
        end

        // Single deals
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Round-robin with both held
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);

        // Exhaust the deck
        while (m_rem > 0) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Refill back-to-back, then reshuffle collides with a request
        for (int i = 0; i < 52; i++) feed(deck[51 - i]);
        step(1'b0, 1'b1, 1'b1);

        // Async reset in the middle of a fill
        for (int i = 0; i < 30; i++) feed(deck[i]);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Duplicate load
        feed(5);
        feed(5);
`ifdef CARD_DEALER_DUP_CHECK_EN
        for (int i = 0; i < 52; i++) feed(deck[i]);
`else
        for (int c = 0; c < 52; c++) begin
            if (c != 5 && c != 6) feed(c);
        end
`endif
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
